// File: rtl/traffic_light_fsm_pkg.sv
// Shared types and constants for the traffic-light sequencer.
// States, lamp codes, reprogram selects and default intervals.
package traffic_light_fsm_pkg;

    typedef enum logic [2:0] {
        S_MG     = 3'd0,
        S_MG_EXT = 3'd1,
        S_MY     = 3'd2,
        S_WALK   = 3'd3,
        S_SG     = 3'd4,
        S_SG_EXT = 3'd5,
        S_SY     = 3'd6
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam int DEF_TICK_DIV = 4;
    localparam int DEF_VAL_W    = 4;
    localparam int DEF_BASE     = 6;
    localparam int DEF_EXT      = 3;
    localparam int DEF_YEL      = 2;

endpackage

// File: rtl/traffic_light_fsm_interval_timer.sv
// Tick divider plus interval counter; expire pulses on the
// final clock of a dur-tick interval.
module interval_timer #(
    parameter int TICK_DIV = 4,
    parameter int VAL_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [VAL_W-1:0] dur,
    output logic             expire
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0]    div;
    logic [VAL_W-1:0] cnt;
    logic             tick;

    assign tick   = (div == DW'(TICK_DIV - 1));
    assign expire = tick && (cnt == dur - VAL_W'(1));

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            div <= '0;
            cnt <= '0;
        end else if (tick) begin
            div <= '0;
            cnt <= cnt + VAL_W'(1);
        end else begin
            div <= div + DW'(1);
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Traffic-light sequencer: main/side/walk phases with programmable
// base, extension and yellow intervals.
module traffic_light_fsm
    import traffic_light_fsm_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int VAL_W      = DEF_VAL_W,
    parameter int T_BASE_DEF = DEF_BASE,
    parameter int T_EXT_DEF  = DEF_EXT,
    parameter int T_YEL_DEF  = DEF_YEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_sync,
    input  logic             wr_sync,
    input  logic             prog_sync,
    input  logic [1:0]       prog_sel,
    input  logic [VAL_W-1:0] prog_val,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic             walk_lamp,
    output logic [2:0]       state_dbg
);

    state_t           state;
    state_t           next;
    logic [VAL_W-1:0] t_base;
    logic [VAL_W-1:0] t_ext;
    logic [VAL_W-1:0] t_yel;
    logic [VAL_W-1:0] dur;
    logic [VAL_W-1:0] wval;
    logic             walk_pend;
    logic             expire;
    logic             restart;

    assign restart   = prog_sync || (next != state);
    assign wval      = (prog_val == '0) ? VAL_W'(1) : prog_val;
    assign state_dbg = state;

    interval_timer #(
        .TICK_DIV(TICK_DIV),
        .VAL_W   (VAL_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .dur    (dur),
        .expire (expire)
    );

    always_comb begin
        dur = t_base;
        case (state)
            S_MG, S_SG:               dur = t_base;
            S_MG_EXT, S_SG_EXT, S_WALK: dur = t_ext;
            S_MY, S_SY:               dur = t_yel;
            default:                  dur = t_base;
        endcase
    end

    always_comb begin
        next = state;
        case (state)
            S_MG:     if (expire) next = sensor_sync ? S_MG_EXT : S_MY;
            S_MG_EXT: if (expire) next = S_MY;
            S_MY:     if (expire) next = walk_pend ? S_WALK : S_SG;
            S_WALK:   if (expire) next = S_SG;
            S_SG:     if (expire) next = sensor_sync ? S_SG_EXT : S_SY;
            S_SG_EXT: if (expire) next = S_SY;
            S_SY:     if (expire) next = S_MG;
            default:  next = S_MG;
        endcase
    end

    always_comb begin
        main_light = RED;
        side_light = RED;
        walk_lamp  = 1'b0;
        case (state)
            S_MG, S_MG_EXT: main_light = GRN;
            S_MY:           main_light = YEL;
            S_WALK:         walk_lamp  = 1'b1;
            S_SG, S_SG_EXT: side_light = GRN;
            S_SY:           side_light = YEL;
            default:        main_light = RED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || prog_sync) begin
            state <= S_MG;
        end else begin
            state <= next;
        end
    end

    // Clear on entry to walk beats any concurrent request.
    always_ff @(posedge clk) begin
        if (rst) begin
            walk_pend <= 1'b0;
        end else if (!prog_sync && state == S_MY && expire && walk_pend) begin
            walk_pend <= 1'b0;
        end else if (wr_sync && state != S_WALK) begin
            walk_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_base <= VAL_W'(T_BASE_DEF);
            t_ext  <= VAL_W'(T_EXT_DEF);
            t_yel  <= VAL_W'(T_YEL_DEF);
        end else if (prog_sync) begin
            case (prog_sel)
                SEL_BASE: t_base <= wval;
                SEL_EXT:  t_ext  <= wval;
                SEL_YEL:  t_yel  <= wval;
                SEL_NONE: ;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for the traffic-light sequencer.
// Measures phase lengths in cycles against hand-computed values.
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sensor_sync = 1'b0;
    logic       wr_sync = 1'b0;
    logic       prog_sync = 1'b0;
    logic [1:0] prog_sel = 2'b11;
    logic [3:0] prog_val = 4'd0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;
    logic [2:0] state_dbg;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  walk_seen;

    traffic_light_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_sync(sensor_sync),
        .wr_sync    (wr_sync),
        .prog_sync  (prog_sync),
        .prog_sel   (prog_sel),
        .prog_val   (prog_val),
        .main_light (main_light),
        .side_light (side_light),
        .walk_lamp  (walk_lamp),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Counts samples spent in the current state; stops on first new state.
    task automatic run_len(output int n);
        logic [2:0] s;
        s = state_dbg;
        n = 1;
        if (walk_lamp) walk_seen = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (state_dbg !== s) break;
            n++;
            if (walk_lamp) walk_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        prog_sync = 1'b1;
        step();
        step();
        prog_sync = 1'b0;
        rst = 1'b0;
        n_cmp++;
        if (state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state got %0d want 0", state_dbg);
        end
        n_cmp++;
        if ({main_light, side_light, walk_lamp} !== 7'b001_100_0) begin
            n_bad++;
            $display("FAIL reset_lamps got %b/%b/%b want 001/100/0",
                     main_light, side_light, walk_lamp);
        end
    endtask

    task automatic test_default();
        int n;
        int tot;
        apply_reset();
        walk_seen = 1'b0;
        tot = 0;
        for (int k = 0; k < 4; k++) begin
            logic [2:0] exp_s;
            int         exp_n;
            exp_s = 3'(k * 2);
            exp_n = (k % 2 == 0) ? 24 : 8;
            n_cmp++;
            if (state_dbg !== exp_s) begin
                n_bad++;
                $display("FAIL dflt_state%0d got %0d want %0d", k, state_dbg, exp_s);
            end
            run_len(n);
            tot += n;
            n_cmp++;
            if (n !== exp_n) begin
                n_bad++;
                $display("FAIL dflt_len%0d got %0d want %0d", k, n, exp_n);
            end
        end
        n_cmp++;
        if (tot !== 64 || state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL dflt_period got %0d/st%0d want 64/st0", tot, state_dbg);
        end
        n_cmp++;
        if (walk_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL dflt_walk got 1 want 0");
        end
    endtask

    task automatic test_sensor();
        int n;
        int exp_n [6] = '{24, 12, 8, 24, 12, 8};
        int exp_s [6] = '{0, 1, 2, 4, 5, 6};
        apply_reset();
        sensor_sync = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (state_dbg !== 3'(exp_s[k])) begin
                n_bad++;
                $display("FAIL sens_state%0d got %0d want %0d", k, state_dbg, exp_s[k]);
            end
            run_len(n);
            n_cmp++;
            if (n !== exp_n[k]) begin
                n_bad++;
                $display("FAIL sens_len%0d got %0d want %0d", k, n, exp_n[k]);
            end
        end
        sensor_sync = 1'b0;
    endtask

    task automatic test_walk();
        int n;
        int cnt;
        apply_reset();
        repeat (5) step();
        wr_sync = 1'b1;
        step();
        wr_sync = 1'b0;
        run_len(n);
        run_len(n);
        n_cmp++;
        if (n !== 8) begin
            n_bad++;
            $display("FAIL walk_my_len got %0d want 8", n);
        end
        n_cmp++;
        if (state_dbg !== 3'd3 ||
            {main_light, side_light, walk_lamp} !== 7'b100_100_1) begin
            n_bad++;
            $display("FAIL walk_entry got st%0d %b/%b/%b want st3 100/100/1",
                     state_dbg, main_light, side_light, walk_lamp);
        end
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            wr_sync = (cnt == 4);
            step();
            if (state_dbg !== 3'd3) break;
            cnt++;
        end
        wr_sync = 1'b0;
        n_cmp++;
        if (cnt !== 12 || state_dbg !== 3'd4) begin
            n_bad++;
            $display("FAIL walk_len got %0d/st%0d want 12/st4", cnt, state_dbg);
        end
        run_len(n);
        run_len(n);
        run_len(n);
        run_len(n);
        n_cmp++;
        if (state_dbg !== 3'd4) begin
            n_bad++;
            $display("FAIL walk_once got st%0d want st4", state_dbg);
        end
    endtask

    task automatic test_prog();
        int n;
        apply_reset();
        run_len(n);
        run_len(n);
        repeat (5) step();
        prog_sel  = 2'b10;
        prog_val  = 4'd5;
        prog_sync = 1'b1;
        step();
        prog_sync = 1'b0;
        n_cmp++;
        if (state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL prog_restart got st%0d want st0", state_dbg);
        end
        run_len(n);
        n_cmp++;
        if (n !== 24) begin
            n_bad++;
            $display("FAIL prog_mg_len got %0d want 24", n);
        end
        run_len(n);
        n_cmp++;
        if (n !== 20) begin
            n_bad++;
            $display("FAIL prog_my_len got %0d want 20", n);
        end
        run_len(n);
        run_len(n);
        prog_sel  = 2'b00;
        prog_val  = 4'd0;
        prog_sync = 1'b1;
        step();
        prog_sync = 1'b0;
        run_len(n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL prog_zero_len got %0d want 4", n);
        end
        run_len(n);
        run_len(n);
        n_cmp++;
        if (n !== 4 || state_dbg !== 3'd6) begin
            n_bad++;
            $display("FAIL prog_sg_len got %0d/st%0d want 4/st6", n, state_dbg);
        end
    endtask

    task automatic test_prog_none();
        int n;
        repeat (3) step();
        prog_sel  = 2'b11;
        prog_val  = 4'd9;
        prog_sync = 1'b1;
        step();
        prog_sync = 1'b0;
        n_cmp++;
        if (state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL none_restart got st%0d want st0", state_dbg);
        end
        run_len(n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL none_mg_len got %0d want 4", n);
        end
        run_len(n);
        n_cmp++;
        if (n !== 20) begin
            n_bad++;
            $display("FAIL none_my_len got %0d want 20", n);
        end
    endtask

    task automatic test_reset_priority();
        int n;
        apply_reset();
        run_len(n);
        run_len(n);
        step();
        wr_sync = 1'b1;
        step();
        wr_sync = 1'b0;
        rst       = 1'b1;
        prog_sync = 1'b1;
        prog_sel  = 2'b00;
        prog_val  = 4'd15;
        step();
        rst       = 1'b0;
        prog_sync = 1'b0;
        n_cmp++;
        if (state_dbg !== 3'd0 || main_light !== 3'b001 || side_light !== 3'b100) begin
            n_bad++;
            $display("FAIL rstpri_state got st%0d %b/%b want st0 001/100",
                     state_dbg, main_light, side_light);
        end
        run_len(n);
        n_cmp++;
        if (n !== 24) begin
            n_bad++;
            $display("FAIL rstpri_mg_len got %0d want 24", n);
        end
        run_len(n);
        n_cmp++;
        if (n !== 8 || state_dbg !== 3'd4) begin
            n_bad++;
            $display("FAIL rstpri_no_walk got %0d/st%0d want 8/st4", n, state_dbg);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_default();
        test_sensor();
        test_walk();
        test_prog();
        test_prog_none();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
